// File: rtl/bbqm_pkg.sv
// -----------------------------------------------------------------------------
// bbqm_pkg
// Shared constants and types for the bank queue manager queue controller.
//   PCOUNT_W        : queue counter width (max queue = 2**PCOUNT_W-1)
//   WTIME_W         : wait-time width, holds CUST_TIME*MAX_P
//   CUST_TIME       : service time per customer in display units
//   DEBOUNCE_CYCLES : stable cycles required per sensor level; only used when
//                     the BBQM_DEBOUNCE_EN macro is defined
//   edge_state_t    : per-sensor edge detector state
// -----------------------------------------------------------------------------
package bbqm_pkg;

  localparam int PCOUNT_W        = 3;
  localparam int WTIME_W         = 5;
  localparam int CUST_TIME       = 3;
  localparam int DEBOUNCE_CYCLES = 4;

  localparam int MAX_P           = (1 << PCOUNT_W) - 1;

  // Debounce counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int DB_CNT_W        = $clog2(DEBOUNCE_CYCLES + 1);

  typedef logic [PCOUNT_W-1:0] pcount_t;
  typedef logic [WTIME_W-1:0]  wtime_t;

  typedef enum logic [1:0] {
    IDLE_LOW = 2'd0,
    EDGE     = 2'd1,
    HIGH     = 2'd2
  } edge_state_t;

endpackage

// File: rtl/bbqm_wait_calc.sv
// -----------------------------------------------------------------------------
// bbqm_wait_calc
// Combinational estimated-wait calculation.
//   Wtime = 0                                   when next_p == 0
//   Wtime = floor(CUST_TIME*(next_p+T-1)/T)     otherwise, T = tcount, 0 -> 1
// Ports:
//   i_next_p  in  PCOUNT_W  queue count the outputs will show next cycle
//   i_tcount  in  2         open tellers (0 is treated as 1)
//   o_wtime   out WTIME_W   estimated wait time
// -----------------------------------------------------------------------------
module bbqm_wait_calc
  import bbqm_pkg::*;
(
  input  logic [PCOUNT_W-1:0] i_next_p,
  input  logic [1:0]          i_tcount,
  output logic [WTIME_W-1:0]  o_wtime
);

  // One spare bit over WTIME_W covers the numerator before division
  // (worst case CUST_TIME*(MAX_P+2) with three tellers).
  localparam int NUM_W = WTIME_W + 1;

  logic [1:0]       w_t;
  logic [NUM_W-1:0] w_num;
  logic [NUM_W-1:0] w_quot;

  always_comb begin
    w_t    = (i_tcount == 2'd0) ? 2'd1 : i_tcount;
    w_num  = NUM_W'(CUST_TIME) * (NUM_W'(i_next_p) + NUM_W'(w_t) - NUM_W'(1));
    w_quot = '0;
    // Divisor is only ever 1, 2 or 3, so use constant divides per case
    // instead of a general variable divider.
    case (w_t)
      2'd1:    w_quot = w_num;
      2'd2:    w_quot = w_num >> 1;
      default: w_quot = w_num / NUM_W'(3);
    endcase
    o_wtime = (i_next_p == '0) ? '0 : WTIME_W'(w_quot);
  end

endmodule

// File: rtl/bbqm_queue_ctrl.sv
// -----------------------------------------------------------------------------
// bbqm_queue_ctrl
// Counts customers in the bank queue from two photocells and produces the
// estimated wait time for the 7-segment display stage. All outputs registered.
//
// Ports:
//   clk         in   1         system clock, rising edge
//   rst_n       in   1         asynchronous active-low reset
//   sensor_in   in   1         front photocell, rising edge = customer joins
//   sensor_out  in   1         rear photocell, rising edge = customer leaves
//   Tcount      in   2         open tellers, 1..3 (0 treated as 1)
//   Pcount      out  PCOUNT_W  customers in queue
//   Wtime       out  WTIME_W   estimated wait time
//   full_flag   out  1         Pcount == MAX_P
//   empty_flag  out  1         Pcount == 0
//   err_pulse   out  1         one-cycle pulse on a rejected join/leave
//
// Optional build macro: BBQM_DEBOUNCE_EN
//   Adds a per-sensor stability filter of DEBOUNCE_CYCLES clocks between the
//   synchronizer and the edge detector (latency 2+DEBOUNCE_CYCLES clocks).
// -----------------------------------------------------------------------------
module bbqm_queue_ctrl
  import bbqm_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sensor_in,
  input  logic                sensor_out,
  input  logic [1:0]          Tcount,
  output logic [PCOUNT_W-1:0] Pcount,
  output logic [WTIME_W-1:0]  Wtime,
  output logic                full_flag,
  output logic                empty_flag,
  output logic                err_pulse
);

  // Index 0 = join sensor, index 1 = leave sensor.
  logic [1:0] w_sensor;
  logic [1:0] w_event;

  assign w_sensor = {sensor_out, sensor_in};

  // ---------------------------------------------------------------------------
  // Per-sensor synchronizer, optional filter and edge detector
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sensor
      logic        r_sync1;
      logic        r_sync2;
      logic [1:0]  r_fill;
      edge_state_t r_state;
      edge_state_t w_state_next;
      logic        w_lvl;
      logic        w_lvl_vld;

      // r_fill marks when the synchronizer holds real samples rather than
      // its reset zeros, so a zero left over from reset is never mistaken
      // for the sensor having been low.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sync1 <= 1'b0;
          r_sync2 <= 1'b0;
          r_fill  <= 2'b00;
        end else begin
          r_sync1 <= w_sensor[gi];
          r_sync2 <= r_sync1;
          r_fill  <= {r_fill[0], 1'b1};
        end
      end

`ifdef BBQM_DEBOUNCE_EN
      logic                r_filt;
      logic                r_filt_vld;
      logic [DB_CNT_W-1:0] r_db_cnt;

      // The filtered level is seeded from the first real sample, then only
      // follows sync2 after DEBOUNCE_CYCLES consecutive differing clocks.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_filt     <= 1'b0;
          r_filt_vld <= 1'b0;
          r_db_cnt   <= '0;
        end else if (!r_filt_vld) begin
          if (r_fill[1]) begin
            r_filt     <= r_sync2;
            r_filt_vld <= 1'b1;
          end
          r_db_cnt <= '0;
        end else if (r_sync2 != r_filt) begin
          if (r_db_cnt == DB_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_filt   <= r_sync2;
            r_db_cnt <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + DB_CNT_W'(1);
          end
        end else begin
          r_db_cnt <= '0;
        end
      end

      assign w_lvl     = r_filt;
      assign w_lvl_vld = r_filt_vld;
`else
      assign w_lvl     = r_sync2;
      assign w_lvl_vld = r_fill[1];
`endif

      // Starting in HIGH means a sensor already high out of reset must be
      // seen low before it can produce an event.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state <= HIGH;
        end else begin
          r_state <= w_state_next;
        end
      end

      always_comb begin
        w_state_next = r_state;
        case (r_state)
          IDLE_LOW: if (w_lvl)               w_state_next = EDGE;
          EDGE:     w_state_next = w_lvl ? HIGH : IDLE_LOW;
          HIGH:     if (w_lvl_vld && !w_lvl) w_state_next = IDLE_LOW;
          default:  w_state_next = HIGH;
        endcase
      end

      // The event is decoded on the IDLE_LOW->EDGE transition itself so the
      // count registers update two clocks after the sampling edge; EDGE then
      // guarantees exactly one event per high level.
      assign w_event[gi] = (r_state == IDLE_LOW) && w_lvl;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Queue counter
  // ---------------------------------------------------------------------------
  logic [PCOUNT_W-1:0] r_pcount;
  logic [WTIME_W-1:0]  r_wtime;
  logic                r_full;
  logic                r_empty;
  logic                r_err;

  logic [PCOUNT_W-1:0] w_next_p;
  logic [WTIME_W-1:0]  w_wtime_next;
  logic                w_err;
  logic                w_join;
  logic                w_leave;

  assign w_join  = w_event[0];
  assign w_leave = w_event[1];

  // Simultaneous join and leave cancel out and are never an error.
  always_comb begin
    w_next_p = r_pcount;
    w_err    = 1'b0;
    if (w_join && !w_leave) begin
      if (r_pcount == PCOUNT_W'(MAX_P)) begin
        w_err = 1'b1;
      end else begin
        w_next_p = r_pcount + PCOUNT_W'(1);
      end
    end else if (w_leave && !w_join) begin
      if (r_pcount == '0) begin
        w_err = 1'b1;
      end else begin
        w_next_p = r_pcount - PCOUNT_W'(1);
      end
    end
  end

  bbqm_wait_calc u_wait_calc (
    .i_next_p (w_next_p),
    .i_tcount (Tcount),
    .o_wtime  (w_wtime_next)
  );

  // Wait time and flags come from the next count so they change on the
  // same edge as Pcount; a Tcount change alone still refreshes Wtime.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcount <= '0;
      r_wtime  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_err    <= 1'b0;
    end else begin
      r_pcount <= w_next_p;
      r_wtime  <= w_wtime_next;
      r_full   <= (w_next_p == PCOUNT_W'(MAX_P));
      r_empty  <= (w_next_p == '0);
      r_err    <= w_err;
    end
  end

  assign Pcount     = r_pcount;
  assign Wtime      = r_wtime;
  assign full_flag  = r_full;
  assign empty_flag = r_empty;
  assign err_pulse  = r_err;

endmodule
